// File: rtl/std_reg_writer_if.sv
// Handshake bundle for std_reg_writer: the valid/ready word input and the
// write/done register port.
interface std_reg_writer_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] reg_in;
    logic             reg_write_en;
    logic             reg_done;

    // Writer side
    modport master (
        input  in_data,
        input  in_valid,
        input  reg_done,
        output in_ready,
        output reg_in,
        output reg_write_en
    );

    // Word source and target register side
    modport slave (
        output in_data,
        output in_valid,
        output reg_done,
        input  in_ready,
        input  reg_in,
        input  reg_write_en
    );
endinterface

// File: rtl/std_reg_writer.sv
// Buffers incoming words in a small FIFO and writes each one into a std_reg
// target, waiting for its done pulse; a timeout drops the word and sets err.
module std_reg_writer #(
    parameter int WIDTH   = 6,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    std_reg_writer_if.master       bus,
    input  logic                   clear_err,
    output logic                   busy,
    output logic                   err,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [TW-1:0]    timer_q;
    logic             err_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push, pop, done_hit, timeout_hit;

    assign bus.in_ready = (count_q < CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    // done on the last allowed WAIT cycle is a success, so it masks the timeout
    assign done_hit     = (state_q == WAIT) && bus.reg_done;
    assign timeout_hit  = (state_q == WAIT) && !bus.reg_done && (timer_q == TW'(TIMEOUT - 1));
    assign pop          = done_hit || timeout_hit;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                timer_q <= '0;
            end else if (state_q == WAIT) begin
                timer_q <= timer_q + TW'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (clear_err) begin
                err_q <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (pop) begin
                    state_d = (count_q > CW'(1)) ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.reg_write_en = (state_q == ISSUE);
        bus.reg_in       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        busy             = (state_q != IDLE) || (count_q != '0);
    end

    assign err   = err_q;
    assign count = count_q;
endmodule

// File: tb/tb_std_reg_writer.sv
// Directed bench for std_reg_writer against a behavioural std_reg target
// whose done pulse can be replaced by a bench-driven pulse.
module tb_std_reg_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear_err = 1'b0;
    logic busy, err;
    logic [2:0] count;

    logic auto_done = 1'b1;
    logic man_done = 1'b0;
    logic tgt_done = 1'b0;
    logic [5:0] tgt_out = 6'h00;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_strobe = 0;
    int b2b_viol = 0;
    logic prev_we = 1'b0;
    int strobe_cyc [64];
    logic [5:0] strobe_data [64];

    std_reg_writer_if #(.WIDTH(6)) bus ();

    std_reg_writer #(.WIDTH(6), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .clear_err (clear_err),
        .busy      (busy),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    assign bus.reg_done = auto_done ? tgt_done : man_done;

    // std_reg target plus strobe log
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        tgt_done <= bus.reg_write_en;
        prev_we  <= bus.reg_write_en;
        if (bus.reg_write_en) begin
            tgt_out <= bus.reg_in;
            if (n_strobe < 64) begin
                strobe_cyc[n_strobe]  <= cyc;
                strobe_data[n_strobe] <= bus.reg_in;
            end
            n_strobe <= n_strobe + 1;
            if (prev_we) b2b_viol <= b2b_viol + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int push_e;
        int base;
        int nstr;

        bus.in_data  = 6'h00;
        bus.in_valid = 1'b0;

        // reset state
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_write_en", 32'(bus.reg_write_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_reg_in", 32'(bus.reg_in), 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // single word
        bus.in_data  = 6'h2A;
        bus.in_valid = 1'b1;
        tick(1);
        push_e = cyc - 1;
        bus.in_valid = 1'b0;
        check("single_count1", 32'(count), 32'd1);
        check("single_we_idle", 32'(bus.reg_write_en), 32'd0);
        tick(1);
        check("single_we", 32'(bus.reg_write_en), 32'd1);
        check("single_reg_in", 32'(bus.reg_in), 32'h2A);
        tick(1);
        check("single_we_off", 32'(bus.reg_write_en), 32'd0);
        check("single_busy_wait", 32'(busy), 32'd1);
        tick(1);
        check("single_busy_end", 32'(busy), 32'd0);
        check("single_count0", 32'(count), 32'd0);
        check("single_tgt", 32'(tgt_out), 32'h2A);
        check("single_nstrobe", 32'(n_strobe), 32'd1);
        check("single_latency", 32'(strobe_cyc[0] - push_e), 32'd2);

        // fill to full with done withheld, then drain with 05 pending
        base = n_strobe;
        auto_done = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = 6'(i);
            tick(1);
        end
        check("fill_count4", 32'(count), 32'd4);
        check("fill_in_ready0", 32'(bus.in_ready), 32'd0);
        bus.in_data = 6'h05;
        tick(1);
        check("full_hold_count", 32'(count), 32'd4);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        auto_done = 1'b1;
        check("pop_count3", 32'(count), 32'd3);
        check("pop_in_ready1", 32'(bus.in_ready), 32'd1);
        check("pop_next_we", 32'(bus.reg_write_en), 32'd1);
        check("pop_next_reg_in", 32'(bus.reg_in), 32'h02);
        tick(1);
        bus.in_valid = 1'b0;
        check("push05_count4", 32'(count), 32'd4);
        tick(7);
        check("drain_count0", 32'(count), 32'd0);
        check("drain_busy0", 32'(busy), 32'd0);
        check("drain_err0", 32'(err), 32'd0);
        check("drain_tgt", 32'(tgt_out), 32'h05);
        check("drain_nstrobe", 32'(n_strobe - base), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain_data%0d", k), 32'(strobe_data[base + k]), 32'(k + 1));
        end
        for (int k = 2; k < 5; k++) begin
            check($sformatf("drain_gap%0d", k), 32'(strobe_cyc[base + k] - strobe_cyc[base + k - 1]), 32'd2);
        end

        // timeout on two words
        base = n_strobe;
        auto_done = 1'b0;
        man_done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 6'h11;
        tick(1);
        bus.in_data = 6'h12;
        tick(1);
        bus.in_valid = 1'b0;
        tick(8);
        check("to_err_before", 32'(err), 32'd0);
        check("to_count_before", 32'(count), 32'd2);
        tick(1);
        check("to_err_set", 32'(err), 32'd1);
        check("to_count_after1", 32'(count), 32'd1);
        check("to_reissue_we", 32'(bus.reg_write_en), 32'd1);
        check("to_reissue_data", 32'(bus.reg_in), 32'h12);
        tick(9);
        check("to_count0", 32'(count), 32'd0);
        check("to_busy0", 32'(busy), 32'd0);
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_strobe_gap", 32'(strobe_cyc[base + 1] - strobe_cyc[base]), 32'd9);
        nstr = n_strobe;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(1);
        check("late_done_nstrobe", 32'(n_strobe), 32'(nstr));
        check("late_done_count", 32'(count), 32'd0);
        check("late_done_busy", 32'(busy), 32'd0);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("clear_err", 32'(err), 32'd0);

        // done exactly in the last WAIT cycle
        bus.in_valid = 1'b1;
        bus.in_data = 6'h33;
        tick(1);
        bus.in_valid = 1'b0;
        tick(8);
        check("edge_busy_before", 32'(busy), 32'd1);
        check("edge_count_before", 32'(count), 32'd1);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        check("edge_count0", 32'(count), 32'd0);
        check("edge_err0", 32'(err), 32'd0);
        check("edge_busy0", 32'(busy), 32'd0);
        tick(1);
        check("edge_err_later", 32'(err), 32'd0);

        // reset mid-WAIT with three words queued
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 6'(6'h21 + i);
            tick(1);
        end
        bus.in_valid = 1'b0;
        tick(1);
        check("mid_count3", 32'(count), 32'd3);
        nstr = n_strobe;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        auto_done = 1'b1;
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_we", 32'(bus.reg_write_en), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        tick(6);
        check("mrst_no_strobe", 32'(n_strobe), 32'(nstr));
        check("mrst_busy_later", 32'(busy), 32'd0);
        check("no_b2b_strobe", 32'(b2b_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/std_reg_writer.md
# std_reg_writer

Initiator side of the std_reg write/done handshake. Accepts data words on a valid/ready input and buffers them in a small FIFO. Drains each word into a downstream std_reg-style register by pulsing `reg_write_en` with the data, then waits for that register's `done` pulse before retiring the word. A timeout sets a sticky error flag so a missing or unresponsive target never hangs the sender.

## Interface
Parameters:
- WIDTH, 6, data width; must match the target register.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TIMEOUT, 8, max WAIT cycles for `reg_done`; ≥2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to enqueue.
- in_valid  input  1  `in_data` is valid.
- in_ready  output  1  FIFO can accept a word; equals `count < DEPTH`.
- reg_in  output  WIDTH  data to target; the FIFO head word (0 when empty).
- reg_write_en  output  1  write strobe to target; high exactly in ISSUE.
- reg_done  input  1  completion pulse from target.
- busy  output  1  `state != IDLE || count != 0`.
- err  output  1  sticky timeout flag.
- clear_err  input  1  clears `err`.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- The FIFO is circular, with `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits (wrap naturally) and a separate `count`.
  - Push occurs when `in_valid && in_ready`.
  - Pop occurs only on retire (see below).
  - A push and a pop in the same cycle leave `count` unchanged.
  - There is no bypass: when full, `in_ready` stays 0 even in a pop cycle.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if `count != 0`, go to ISSUE; otherwise stay.
  - ISSUE: `reg_write_en = 1` and `reg_in` = head. Always go to WAIT next cycle. Clear `timer` to 0.
  - WAIT: `timer` increments each cycle.
    - If `reg_done`: retire the head (pop). Go to ISSUE if `count > 1`, else IDLE.
    - Else if `timer == TIMEOUT-1`: set `err` and retire the head (dropped). Same next-state rule as a normal retire.
    - Else stay in WAIT.
- `reg_done` in the same cycle as the timeout limit counts as success; `err` is not set.
- `reg_done` is ignored in IDLE and ISSUE (stray or late pulses have no effect).
- `err` is set by timeout and cleared by `clear_err`. If both occur in the same cycle, set wins.
- `reg_in` is driven from the head in all states, so it is stable through ISSUE and WAIT.

## Timing
- Reset values: state IDLE, `count` 0, pointers 0, `timer` 0, `err` 0. Outputs after reset: `reg_write_en` 0, `in_ready` 1, `busy` 0, `reg_in` 0.
- Reset mid-operation (any state) discards all buffered words and any in-flight write. No retire occurs.
- Latency from push to strobe:
  - A word pushed at edge E into an empty, idle FIFO is seen by IDLE in cycle E+1.
  - `reg_write_en` is high in cycle E+2.
- With a std_reg target, `done` arrives in the cycle after `reg_write_en`, so a word retires 2 cycles after its strobe.
- Back-to-back throughput is one write per 2 cycles: ISSUE, WAIT, ISSUE, WAIT, …
- `reg_write_en` is never high for two consecutive cycles.
- Timeout: with no `done`, the word is retired at the end of the TIMEOUT-th WAIT cycle. `err` is visible the following cycle.

## Test plan
- Single word: reset, then push 6'h2A. Required: `reg_write_en` pulses once, 2 cycles after the push edge, with `reg_in` = 6'h2A. The std_reg target then holds 2A. `busy` falls after the retire, and `count` returns to 0.
- Fill and drain: push 6'h01–6'h04 back-to-back (DEPTH=4). Required: `in_ready` = 0 at `count` = 4. The target receives 01, 02, 03, 04 in order, with strobes exactly 2 cycles apart and `err` = 0 throughout.
- Push while full and popping: keep `in_valid` high with 6'h05 while full. Required: 05 is accepted only after `count` drops to 3, and is written last.
- Timeout: tie `reg_done` = 0 and push 6'h11, 6'h12. Required: each word is dropped after 8 WAIT cycles and `err` = 1. A late `reg_done` pulse in IDLE has no effect. `clear_err` returns `err` to 0.
- Boundary: assert `reg_done` exactly in WAIT cycle 8. Required: the word is retired as success and `err` stays 0.
- Reset mid-WAIT with 3 words queued. Required: the next cycle shows `count` = 0, `reg_write_en` = 0 and `busy` = 0, and no further strobes occur.
